// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_IDX_W  = 7;
  localparam int ICACHE_ADDR_W = 18;
  localparam int ICACHE_TAG_W  = ICACHE_ADDR_W - ICACHE_IDX_W - 2;
  localparam int ICACHE_LINES  = 1 << ICACHE_IDX_W;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one async read port, one write port
// and a flash-clear of all valid bits that takes priority over a same-cycle write.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = ICACHE_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  input  logic             clr
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tag and data are qualified by valid_q, so they are left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache between IF and mem_ctrl.
// Define ICACHE_STATS_EN to add saturating hit/miss counter ports.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int ADDR_W = ICACHE_ADDR_W
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] inst_addr_in,
  input  logic        branch_in,
  input  logic        inv_in,
  output logic [31:0] inst_out,
  output logic        inst_done_out,
  output logic        mc_req_out,
  output logic [31:0] mc_addr_out,
  input  logic [31:0] mc_inst_in,
  input  logic        mc_done_in,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out,
`endif
  output logic        state_dbg_out
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Handshakes: a request is a level held by its source until the matching done,
  // and done is a single-cycle registered pulse; rdy_in=0 freezes every register.
  icache_state_e state_q, state_d;
  logic          cancel_q;
  logic          inv_seen_q;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;

  logic lookup, hit, miss, fill, deliver_fill;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^inst_addr_in[1:0];

  assign lookup = (state_q == ICACHE_IDLE) && if_req_in && !branch_in && !inst_done_out;
  assign hit    = lookup && rd_valid && (rd_tag == inst_addr_in[ADDR_W-1:IDX_W+2]);
  assign miss   = lookup && !hit;
  assign fill   = (state_q == ICACHE_MISS) && mc_done_in;
  // A redirect or dropped request on the fill cycle itself also suppresses delivery.
  assign deliver_fill = fill && !cancel_q && !branch_in && if_req_in;

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .rd_idx   (inst_addr_in[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill && rdy_in),
    .wr_idx   (mc_addr_out[IDX_W+1:2]),
    .wr_tag   (mc_addr_out[ADDR_W-1:IDX_W+2]),
    .wr_data  (mc_inst_in),
    .wr_valid (!inv_seen_q),
    .clr      (inv_in && rdy_in)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_IDLE: if (miss) state_d = ICACHE_MISS;
      ICACHE_MISS: if (mc_done_in) state_d = ICACHE_IDLE;
      default:     state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ICACHE_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      inst_done_out <= 1'b0;
      inst_out      <= 32'd0;
      mc_req_out    <= 1'b0;
      mc_addr_out   <= 32'd0;
      cancel_q      <= 1'b0;
      inv_seen_q    <= 1'b0;
    end else if (rdy_in) begin
      inst_done_out <= hit || deliver_fill;
      if (hit) begin
        inst_out <= rd_data;
      end else if (deliver_fill) begin
        inst_out <= mc_inst_in;
      end

      // mc_addr_out doubles as the latched miss address used for the fill write.
      if (miss) begin
        mc_req_out  <= 1'b1;
        mc_addr_out <= {inst_addr_in[31:2], 2'b00};
      end else if (fill) begin
        mc_req_out  <= 1'b0;
      end

      if (miss) begin
        cancel_q <= 1'b0;
      end else if ((state_q == ICACHE_MISS) && (branch_in || !if_req_in)) begin
        cancel_q <= 1'b1;
      end

      if (miss) begin
        inv_seen_q <= 1'b0;
      end else if ((state_q == ICACHE_MISS) && inv_in) begin
        inv_seen_q <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt_out  <= 32'd0;
      miss_cnt_out <= 32'd0;
    end else if (rdy_in) begin
      if (hit)  hit_cnt_out  <= sat_inc(hit_cnt_out);
      if (miss) miss_cnt_out <= sat_inc(miss_cnt_out);
    end
  end
`endif

  assign state_dbg_out = (state_q == ICACHE_MISS);

endmodule
